lts_pair_feeder: RTL

Upstream feeder for the per-subcarrier complex divider in the OFDM equalizer path. Averages the two long training symbols (LTS) into a per-bin channel estimate held in an internal FFT_SIZE-entry memory. It then streams every subsequent data-symbol sample paired with the estimate of its bin, so the divider sees `a` = received sample and `b` = channel estimate. The output is strobe-only with no backpressure, matching the divider's input.

---
 rtl/lts_pair_feeder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lts_pair_feeder.sv
// lts_pair_feeder: averages two LTS symbols into a per-bin channel estimate,
// then streams each data sample paired with its bin estimate to the divider.
//
// Ports:
//   clock, reset (sync, active-low), enable (freeze when 0)
//   lts_start             : restart training; coincident strobe is LTS1 bin 0
//   in_i, in_q, in_strobe : frequency-domain input samples
//   a_i, a_q              : registered data sample
//   b_i, b_q              : registered channel estimate for the same bin
//   out_bin, b_zero       : bin index, estimate == 0+0j
//   out_strobe            : one-cycle pulse per data sample
//   est_valid             : estimate complete (state DATA)
module lts_pair_feeder #(
    parameter  int DATA_WIDTH = 16,
    parameter  int FFT_SIZE   = 64,
    localparam int AW         = $clog2(FFT_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  lts_start,
    input  logic [DATA_WIDTH-1:0] in_i,
    input  logic [DATA_WIDTH-1:0] in_q,
    input  logic                  in_strobe,
    output logic [DATA_WIDTH-1:0] a_i,
    output logic [DATA_WIDTH-1:0] a_q,
    output logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] b_q,
    output logic [AW-1:0]         out_bin,
    output logic                  b_zero,
    output logic                  out_strobe,
    output logic                  est_valid
);

    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LTS1,
        LTS2,
        DATA
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]   idx_q, idx_d;
    logic            pend_q, pend_d;
    logic [AW-1:0]   pend_addr_q, pend_addr_d;
    logic [DW-1:0]   rd_re_q, rd_re_d;
    logic [DW-1:0]   rd_im_q, rd_im_d;
    logic [DW-1:0]   sav_re_q, sav_re_d;
    logic [DW-1:0]   sav_im_q, sav_im_d;
    logic [DW-1:0]   a_i_q, a_i_d;
    logic [DW-1:0]   a_q_q, a_q_d;
    logic [DW-1:0]   b_i_q, b_i_d;
    logic [DW-1:0]   b_q_q, b_q_d;
    logic [AW-1:0]   out_bin_q, out_bin_d;
    logic            b_zero_q, b_zero_d;
    logic            out_strobe_q, out_strobe_d;
    logic            est_valid_q, est_valid_d;

    logic [2*DW-1:0] mem [FFT_SIZE];
    logic [2*DW-1:0] mem_rd;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [2*DW-1:0] wr_data;

    logic [DW:0]     sum_re;
    logic [DW:0]     sum_im;
    logic            last_bin;

    // Sign-extended sum; bits [DW:1] are the floor-halved result.
    assign sum_re   = {rd_re_q[DW-1], rd_re_q} + {sav_re_q[DW-1], sav_re_q};
    assign sum_im   = {rd_im_q[DW-1], rd_im_q} + {sav_im_q[DW-1], sav_im_q};
    assign mem_rd   = mem[idx_q];
    assign last_bin = (idx_q == AW'(FFT_SIZE - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        rd_re_d      = rd_re_q;
        rd_im_d      = rd_im_q;
        sav_re_d     = sav_re_q;
        sav_im_d     = sav_im_q;
        a_i_d        = a_i_q;
        a_q_d        = a_q_q;
        b_i_d        = b_i_q;
        b_q_d        = b_q_q;
        out_bin_d    = out_bin_q;
        b_zero_d     = b_zero_q;
        out_strobe_d = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = idx_q;
        wr_data      = {in_i, in_q};

        if (enable) begin
            pend_d = 1'b0;
            // LTS2 write-back lands one cycle after its read; a restart
            // drops it since the new LTS1 overwrites memory anyway.
            if (pend_q && !lts_start) begin
                wr_en   = 1'b1;
                wr_addr = pend_addr_q;
                wr_data = {sum_re[DW:1], sum_im[DW:1]};
            end
            if (lts_start) begin
                state_d = LTS1;
                idx_d   = '0;
                if (in_strobe) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wr_data = {in_i, in_q};
                    idx_d   = AW'(1);
                end
            end else if (in_strobe) begin
                unique case (state_q)
                    IDLE: ;
                    LTS1: begin
                        wr_en   = 1'b1;
                        wr_addr = idx_q;
                        wr_data = {in_i, in_q};
                        idx_d   = idx_q + AW'(1);
                        if (last_bin) state_d = LTS2;
                    end
                    LTS2: begin
                        rd_re_d     = mem_rd[2*DW-1:DW];
                        rd_im_d     = mem_rd[DW-1:0];
                        sav_re_d    = in_i;
                        sav_im_d    = in_q;
                        pend_d      = 1'b1;
                        pend_addr_d = idx_q;
                        idx_d       = idx_q + AW'(1);
                        if (last_bin) state_d = DATA;
                    end
                    DATA: begin
                        a_i_d        = in_i;
                        a_q_d        = in_q;
                        b_i_d        = mem_rd[2*DW-1:DW];
                        b_q_d        = mem_rd[DW-1:0];
                        b_zero_d     = (mem_rd == '0);
                        out_bin_d    = idx_q;
                        out_strobe_d = 1'b1;
                        idx_d        = idx_q + AW'(1);
                    end
                endcase
            end
        end

        est_valid_d = (state_d == DATA);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            rd_re_q      <= '0;
            rd_im_q      <= '0;
            sav_re_q     <= '0;
            sav_im_q     <= '0;
            a_i_q        <= '0;
            a_q_q        <= '0;
            b_i_q        <= '0;
            b_q_q        <= '0;
            out_bin_q    <= '0;
            b_zero_q     <= 1'b0;
            out_strobe_q <= 1'b0;
            est_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            rd_re_q      <= rd_re_d;
            rd_im_q      <= rd_im_d;
            sav_re_q     <= sav_re_d;
            sav_im_q     <= sav_im_d;
            a_i_q        <= a_i_d;
            a_q_q        <= a_q_d;
            b_i_q        <= b_i_d;
            b_q_q        <= b_q_d;
            out_bin_q    <= out_bin_d;
            b_zero_q     <= b_zero_d;
            out_strobe_q <= out_strobe_d;
            est_valid_q  <= est_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign a_i        = a_i_q;
    assign a_q        = a_q_q;
    assign b_i        = b_i_q;
    assign b_q        = b_q_q;
    assign out_bin    = out_bin_q;
    assign b_zero     = b_zero_q;
    assign out_strobe = out_strobe_q;
    assign est_valid  = est_valid_q;

endmodule
